// File: rtl/shift_serializer_pkg.sv
// shift_serializer_pkg: shared FSM state type for the serializer
package shift_serializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/shift_serializer.sv
// shift_serializer: parallel word to LSB-first lane serializer with beat strobe and underrun detect
// Ports: clk/reset (sync, active-high); enable beat strobe; in_valid/in_ready/in_data/in_last word input;
//        out_valid/out_data/out_last beat output; underrun one-cycle pulse when a frame starves.
module shift_serializer
  import shift_serializer_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int LANEW = 2,
  parameter int BEATS = DATAW / LANEW,
  parameter int BEATW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  output logic [LANEW-1:0] out_data,
  output logic             out_last,
  output logic             underrun
);
  if (DATAW % LANEW != 0) begin : g_bad_width
    $error("shift_serializer: DATAW must be a multiple of LANEW");
  end
  localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(BEATS - 1);
  state_t           r_state;
  logic [DATAW-1:0] r_sreg;
  logic [BEATW-1:0] r_beat;
  logic             r_word_last;
  logic             r_underrun;
  logic             w_at_end;
  logic             w_accept;
  // final beat is being consumed this cycle; the slot is free for the next word
  assign w_at_end  = r_state == SHIFT && r_beat == LAST_BEAT && enable;
  assign in_ready  = !reset && (r_state == IDLE || w_at_end);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_state == SHIFT;
  assign out_data  = r_sreg[LANEW-1:0];
  assign out_last  = out_valid && r_word_last && r_beat == LAST_BEAT;
  assign underrun  = r_underrun;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sreg      <= '0;
      r_beat      <= '0;
      r_word_last <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_accept) begin
        r_state     <= SHIFT;
        r_sreg      <= in_data;
        r_beat      <= '0;
        r_word_last <= in_last;
      end else if (w_at_end) begin
        // starving after a non-final word means the frame was cut short
        r_state     <= IDLE;
        r_sreg      <= '0;
        r_beat      <= '0;
        r_word_last <= 1'b0;
        r_underrun  <= !r_word_last;
      end else if (r_state == SHIFT && enable) begin
        r_sreg <= r_sreg >> LANEW;
        r_beat <= r_beat + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: directed self-checking bench for shift_serializer
module tb_shift_serializer;
  logic       clk = 1'b0;
  logic       reset, enable, in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_last, underrun;
  logic [1:0] out_data;
  logic       en2, v2, l2;
  logic [3:0] d2;
  logic       rdy2, ov2, ol2, ur2;
  logic [3:0] od2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  shift_serializer dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .underrun(underrun)
  );
  shift_serializer #(.DATAW(4), .LANEW(4)) dut1 (
    .clk(clk), .reset(reset), .enable(en2), .in_valid(v2), .in_ready(rdy2),
    .in_data(d2), .in_last(l2), .out_valid(ov2), .out_data(od2),
    .out_last(ol2), .underrun(ur2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [1:0] b2b [8] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] thr [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] b40 [4] = '{2'd3, 2'd3, 2'd0, 2'd0};
    reset = 1; enable = 1; in_valid = 0; in_data = 0; in_last = 0;
    en2 = 0; v2 = 0; d2 = 0; l2 = 0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_ready", 32'(in_ready), 0);
    reset = 0; in_valid = 1; in_data = 8'hB4; in_last = 1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    chk("b1_d0", 32'(out_data), 0);
    chk("b1_v0", 32'(out_valid), 1);
    chk("b1_l0", 32'(out_last), 0);
    tick();
    chk("b1_d1", 32'(out_data), 1);
    chk("b1_l1", 32'(out_last), 0);
    tick();
    chk("b1_d2", 32'(out_data), 3);
    chk("b1_l2", 32'(out_last), 0);
    tick();
    chk("b1_d3", 32'(out_data), 2);
    chk("b1_l3", 32'(out_last), 1);
    tick();
    chk("b1_idle_valid", 32'(out_valid), 0);
    chk("b1_idle_data", 32'(out_data), 0);
    chk("b1_no_underrun", 32'(underrun), 0);
    in_valid = 1; in_data = 8'h1B; in_last = 0;
    tick();
    in_data = 8'hE4; in_last = 1;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        in_valid = 0;
        #1;
      end
      chk($sformatf("b2b_valid%0d", k), 32'(out_valid), 1);
      chk($sformatf("b2b_data%0d", k), 32'(out_data), 32'(b2b[k]));
      chk($sformatf("b2b_ready%0d", k), 32'(in_ready), 32'(k == 3 || k == 7));
      chk($sformatf("b2b_last%0d", k), 32'(out_last), 32'(k == 7));
      tick();
    end
    chk("b2b_idle", 32'(out_valid), 0);
    chk("b2b_no_underrun", 32'(underrun), 0);
    in_valid = 1; in_data = 8'hFF; in_last = 0;
    tick();
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ur_data%0d", k), 32'(out_data), 3);
      chk($sformatf("ur_pulse_early%0d", k), 32'(underrun), 0);
      tick();
    end
    chk("ur_pulse", 32'(underrun), 1);
    chk("ur_valid", 32'(out_valid), 0);
    tick();
    chk("ur_pulse_end", 32'(underrun), 0);
    enable = 0; in_valid = 1; in_data = 8'h39; in_last = 1;
    #1;
    chk("thr_ready_idle_noen", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    for (int c = 0; c < 20; c++) begin
      enable = (c % 5 == 4);
      #1;
      chk($sformatf("thr_valid%0d", c), 32'(out_valid), 1);
      chk($sformatf("thr_data%0d", c), 32'(out_data), 32'(thr[c/5]));
      tick();
    end
    enable = 1;
    chk("thr_idle", 32'(out_valid), 0);
    chk("thr_no_underrun", 32'(underrun), 0);
    in_valid = 1; in_data = 8'hB4; in_last = 0;
    tick();
    in_valid = 0;
    chk("mid_d0", 32'(out_data), 0);
    tick();
    chk("mid_d1", 32'(out_data), 1);
    reset = 1;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 0);
    tick();
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_data", 32'(out_data), 0);
    chk("mid_last", 32'(out_last), 0);
    chk("mid_underrun", 32'(underrun), 0);
    reset = 0; in_valid = 1; in_data = 8'h0F; in_last = 1;
    #1;
    chk("mid_ready_after", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid_new%0d", k), 32'(out_data), 32'(b40[k]));
      chk($sformatf("mid_under%0d", k), 32'(underrun), 0);
      tick();
    end
    chk("mid_new_idle", 32'(out_valid), 0);
    chk("mid_new_no_underrun", 32'(underrun), 0);
    en2 = 1; v2 = 1; d2 = 4'hA; l2 = 0;
    #1;
    chk("b1w_ready_idle", 32'(rdy2), 1);
    tick();
    d2 = 4'h5; l2 = 1;
    #1;
    chk("b1w_valid_a", 32'(ov2), 1);
    chk("b1w_data_a", 32'(od2), 32'hA);
    chk("b1w_last_a", 32'(ol2), 0);
    chk("b1w_ready_shift", 32'(rdy2), 1);
    en2 = 0;
    #1;
    chk("b1w_ready_noen", 32'(rdy2), 0);
    en2 = 1;
    tick();
    v2 = 0;
    chk("b1w_data_5", 32'(od2), 32'h5);
    chk("b1w_last_5", 32'(ol2), 1);
    tick();
    chk("b1w_idle", 32'(ov2), 0);
    chk("b1w_no_underrun", 32'(ur2), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_serializer.md
SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 The block SHALL have parameter DATAW, default 8, meaning the parallel input word width.
REQ-002 The block SHALL have parameter LANEW, default 2, meaning the serial lane width in bits per beat; DATAW SHALL be an integer multiple of LANEW.
REQ-003 The block SHALL have parameter BEATS, default DATAW/LANEW, meaning the number of beats per word.
REQ-004 The block SHALL have parameter BEATW, default $clog2(BEATS), meaning the beat counter width (minimum 1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port enable, input, 1 bit: the beat strobe; the serial output advances only on cycles where it is high.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the input word is valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-010 The block SHALL have port in_data, input, DATAW bits: the parallel word.
REQ-011 The block SHALL have port in_last, input, 1 bit: the word is the final word of a frame.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data holds a live beat.
REQ-013 The block SHALL have port out_data, output, LANEW bits: the current beat, LSB-first.
REQ-014 The block SHALL have port out_last, output, 1 bit: the current beat is the final beat of a frame.
REQ-015 The block SHALL have port underrun, output, 1 bit: a one-cycle pulse when a frame starves mid-frame.

Function
REQ-016 The block SHALL implement two states, IDLE and SHIFT.
REQ-017 A word SHALL be accepted on a rising clk edge where in_valid && in_ready are both high.
REQ-018 in_ready SHALL be high in IDLE, irrespective of enable.
REQ-019 In SHIFT, in_ready SHALL be high only when beat == BEATS-1 && enable, so back-to-back words are accepted with zero bubbles.
REQ-020 On accept, the block SHALL load the shift register with in_data, latch in_last into word_last, clear beat to 0, and enter SHIFT.
REQ-021 The first beat SHALL appear on out_data one cycle after accept.
REQ-022 out_data SHALL equal sreg[LANEW-1:0] in every cycle.
REQ-023 In SHIFT with enable high and beat < BEATS-1, the block SHALL shift sreg right by LANEW and increment beat.
REQ-024 In SHIFT with enable low, sreg, beat and all outputs SHALL hold.
REQ-025 In SHIFT with enable high and beat == BEATS-1:
- if a word is accepted, the block SHALL reload per REQ-020;
- otherwise it SHALL go to IDLE, with out_valid and out_data set to 0 on the next cycle.
REQ-026 The underrun pulse SHALL be asserted in the cycle after the REQ-025 IDLE transition when word_last was 0; it SHALL NOT be asserted after a word with word_last = 1.
REQ-027 out_valid SHALL be 1 exactly while in SHIFT.
REQ-028 out_last SHALL equal out_valid && word_last && (beat == BEATS-1).
REQ-029 With BEATS == 1, every accepted word SHALL produce one beat, and in_ready SHALL equal (IDLE || enable).

Reset
REQ-030 While reset is high:
- state SHALL be IDLE, and sreg, beat and word_last SHALL be 0;
- out_valid, out_data, out_last and underrun SHALL be 0;
- in_ready SHALL be forced to 0.
REQ-031 Reset mid-word SHALL discard the word in flight without raising underrun.
REQ-032 A word presented in the first cycle after reset deasserts SHALL be accepted.

Structure
REQ-033 The state enum typedef SHALL be placed in the shared common package.
REQ-034 The parameter legality check (DATAW % LANEW == 0) SHALL be an elaboration-time assertion in the module.
REQ-035 The block SHALL have no sub-module; the counter, shifter and FSM SHALL be inline in a single module of roughly 150 lines.

Verification
REQ-036 Basic shift: DATAW=8, LANEW=2, enable=1, one word 0xB4 with last=1 -> out_data 0,1,3,2 on cycles 1-4, out_last only on cycle 4, no underrun.
REQ-037 Back-to-back: words 0x1B, 0xE4 (last on the second), enable=1 -> 8 contiguous beats 3,2,1,0,0,1,2,3 with no out_valid gap; in_ready high only on the beat-3 cycles.
REQ-038 Underrun: a word 0xFF with last=0 and no follow-up word -> four beats of 3, then underrun=1 for one cycle, then out_valid=0.
REQ-039 Enable throttle: enable high every 5th cycle, word 0x39 -> beats 1,2,3,0, each held for 5 cycles, with 20 cycles total in SHIFT.
REQ-040 Reset mid-word: reset asserted after beat 1 of 0xB4 -> all outputs 0 on the next cycle, no underrun, and a new word 0x0F after reset yields 3,3,0,0.
REQ-041 BEATS=1 corner: DATAW=LANEW=4, words 0xA, 0x5 back-to-back -> out_data A, 5 on consecutive cycles.
